// File: rtl/ti_write_arbiter.sv
// Round-robin arbiter and byte formatter that owns the sound core write bus (nCE/nWE/D/READY); TI_WR_TIMEOUT_EN adds a per-phase handshake timeout.
// Latency: req seen in IDLE at cycle N gives gnt and D at N+1 and nCE low at N+2; at least one IDLE cycle between commands.
// Backpressure: requesters hold req until gnt; each byte stalls in STROBE/RELEASE until synchronised READY answers.
module ti_write_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 CLK100MHZ,
  input  logic                 CPU_RESETN,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_chan,
  input  logic [NREQ-1:0]      req_vol,
  input  logic [10*NREQ-1:0]   req_val,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 nCE,
  output logic                 nWE,
  output logic [7:0]           D,
  input  logic                 READY,
  output logic                 err_timeout
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("ti_write_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;
  state_t state, state_nxt;

  logic [1:0]      rdy_sync;
  logic            rdy_s;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   sel_idx, hi_idx, lo_idx;
  logic            sel_vld, hi_vld;
  logic [NREQ-1:0] sel_oh;
  logic [1:0]      s_chan;
  logic            s_vol;
  logic [9:0]      s_val;
  logic [7:0]      byte1_q;
  logic            two_q;
  logic            strobe_n;
  logic            grant, load_b1;

  function automatic logic [7:0] fmt_byte0(input logic [1:0] chan, input logic vol,
                                           input logic [9:0] val);
    if (vol)
      return {1'b1, chan, 1'b1, val[3:0]};
    else if (chan == 2'd3)
      return {5'b11100, val[2:0]};
    else
      return {1'b1, chan, 1'b0, val[3:0]};
  endfunction

  // READY comes straight from the sound core clock domain
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) rdy_sync <= 2'b11;
    else             rdy_sync <= {rdy_sync[0], READY};
  end
  assign rdy_s = rdy_sync[1];

  // First requester at or above the pointer wins, else the lowest one (wrap)
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = PW'(i);
      if (req[i] && i >= int'(ptr)) begin
        hi_vld = 1'b1;
        hi_idx = PW'(i);
      end
    end
    sel_vld = |req;
    sel_idx = hi_vld ? hi_idx : lo_idx;
    ptr_nxt = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_comb begin
    sel_oh = '0;
    s_chan = '0;
    s_vol  = 1'b0;
    s_val  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == PW'(i)) begin
        sel_oh[i] = 1'b1;
        s_chan    = req_chan[2*i +: 2];
        s_vol     = req_vol[i];
        s_val     = req_val[10*i +: 10];
      end
    end
  end

`ifdef TI_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          abort;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    load_b1   = 1'b0;
`ifdef TI_WR_TIMEOUT_EN
    abort     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = STROBE;
      STROBE: begin
        if (!rdy_s) state_nxt = RELEASE;
`ifdef TI_WR_TIMEOUT_EN
        else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      RELEASE: begin
        if (rdy_s) begin
          if (two_q) begin
            load_b1   = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
`ifdef TI_WR_TIMEOUT_EN
        else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      ptr      <= '0;
      gnt      <= '0;
      D        <= '0;
      byte1_q  <= '0;
      two_q    <= 1'b0;
      strobe_n <= 1'b1;
    end else begin
      gnt      <= grant ? sel_oh : '0;
      strobe_n <= (state_nxt != STROBE);
      if (grant) begin
        ptr     <= ptr_nxt;
        D       <= fmt_byte0(s_chan, s_vol, s_val);
        byte1_q <= {2'b00, s_val[9:4]};
        two_q   <= !s_vol && (s_chan != 2'd3);
      end
      if (load_b1) begin
        D     <= byte1_q;
        two_q <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign nCE  = strobe_n;
  assign nWE  = strobe_n;

`ifdef TI_WR_TIMEOUT_EN
  // Counter restarts on each phase entry and saturates elsewhere
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state_nxt != state && (state_nxt == STROBE || state_nxt == RELEASE))
        tmo_cnt <= '0;
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (abort) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ti_write_arbiter.sv
// Randomised bench for ti_write_arbiter with a reference arbiter/formatter model and a READY-answering sound core model.
module tb_ti_write_arbiter;
  localparam int NREQ = 4;
`ifdef TI_WR_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic              CLK100MHZ = 1'b0;
  logic              CPU_RESETN;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_chan;
  logic [NREQ-1:0]   req_vol;
  logic [10*NREQ-1:0] req_val;
  logic [NREQ-1:0]   gnt;
  logic              busy, nCE, nWE, err_timeout;
  logic [7:0]        D;
  logic              READY = 1'b1;

  bit         c_req[NREQ];
  logic [1:0] c_chan[NREQ];
  logic       c_vol[NREQ];
  logic [9:0] c_val[NREQ];

  int checks = 0;
  int failures = 0;
  int m_ptr = 0;
  int gnt_pulses = 0;
  int gnt_multi = 0;
  bit rdy_auto = 1'b1;
  int rdy_dly;
  logic [7:0] bus_q[$];
  logic [7:0] exp_q[$];

  ti_write_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .req(req), .req_chan(req_chan),
    .req_vol(req_vol), .req_val(req_val), .gnt(gnt), .busy(busy), .nCE(nCE), .nWE(nWE),
    .D(D), .READY(READY), .err_timeout(err_timeout)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  always_comb begin
    req = '0; req_chan = '0; req_vol = '0; req_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      req[i]              = c_req[i];
      req_chan[2*i +: 2]  = c_chan[i];
      req_vol[i]          = c_vol[i];
      req_val[10*i +: 10] = c_val[i];
    end
  end

  // Sound core model: drops READY some cycles after a strobe, raises it after release
  always begin
    @(negedge CLK100MHZ);
    if (rdy_auto && nCE === 1'b0 && READY === 1'b1) begin
      rdy_dly = $urandom_range(0, 3);
      repeat (rdy_dly) @(negedge CLK100MHZ);
      if (nCE === 1'b0) begin
        bus_q.push_back(D);
        READY = 1'b0;
        while (nCE === 1'b0) @(negedge CLK100MHZ);
        rdy_dly = $urandom_range(0, 3);
        repeat (rdy_dly) @(negedge CLK100MHZ);
        READY = 1'b1;
      end
    end
  end

  always @(negedge CLK100MHZ) begin
    if (gnt !== '0) gnt_pulses++;
    if ($countones(gnt) > 1) gnt_multi++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] sh;
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      sh  = mask >> idx;
      if (sh[0]) return idx;
    end
    return -1;
  endfunction

  function automatic void push_exp(input int i);
    int ch, v;
    ch = int'(c_chan[i]);
    v  = int'(c_val[i]);
    if (c_vol[i]) exp_q.push_back(8'(144 + ch * 32 + v % 16));
    else if (ch == 3) exp_q.push_back(8'(224 + v % 8));
    else begin
      exp_q.push_back(8'(128 + ch * 32 + v % 16));
      exp_q.push_back(8'(v / 16));
    end
  endfunction

  function automatic void rand_cmd(input int i);
    c_chan[i] = 2'($urandom_range(0, 3));
    c_vol[i]  = 1'($urandom_range(0, 1));
    c_val[i]  = 10'($urandom_range(0, 1023));
  endfunction

  task automatic wait_gnt(output logic [NREQ-1:0] g, output bit ok);
    g = '0; ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK100MHZ);
      if (gnt !== '0) begin g = gnt; ok = 1'b1; return; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK100MHZ);
      if (busy === 1'b0) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset;
    checks++; if (nCE !== 1'b1 || nWE !== 1'b1) begin failures++; $display("FAIL rst_strobe_in_reset nCE=%b nWE=%b exp 1/1", nCE, nWE); end
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    @(negedge CLK100MHZ);
    checks++; if (nCE !== 1'b1) begin failures++; $display("FAIL rst_nce got=%b exp=1", nCE); end
    checks++; if (nWE !== 1'b1) begin failures++; $display("FAIL rst_nwe got=%b exp=1", nWE); end
    checks++; if (D !== 8'h00) begin failures++; $display("FAIL rst_d got=%h exp=00", D); end
    checks++; if (gnt !== '0) begin failures++; $display("FAIL rst_gnt got=%b exp=0", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_timeout); end
  endtask

  task automatic test_tone;
    bit ok;
    int base;
    base = bus_q.size();
    exp_q.delete();
    c_chan[0] = 2'd0; c_vol[0] = 1'b0; c_val[0] = 10'h3F9; c_req[0] = 1'b1;
    @(negedge CLK100MHZ);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL tone_gnt got=%b exp=0001", gnt); end
    checks++; if (D !== 8'h89) begin failures++; $display("FAIL tone_d0 got=%h exp=89", D); end
    checks++; if (nCE !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL tone_setup nCE=%b busy=%b exp 1/1", nCE, busy); end
    c_req[0] = 1'b0;
    m_ptr = 1;
    @(negedge CLK100MHZ);
    checks++; if (nCE !== 1'b0 || nWE !== 1'b0) begin failures++; $display("FAIL tone_strobe nCE=%b nWE=%b exp 0/0", nCE, nWE); end
    checks++; if (gnt !== '0) begin failures++; $display("FAIL tone_gnt_pulse got=%b exp=0", gnt); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL tone_idle busy stuck got=%b exp=0", busy); end
    checks++; if (nCE !== 1'b1 || D !== 8'h3F) begin failures++; $display("FAIL tone_end nCE=%b D=%h exp 1/3F", nCE, D); end
    exp_q.push_back(8'h89); exp_q.push_back(8'h3F);
    checks++;
    if (bus_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL tone_nbytes got=%0d exp=%0d", bus_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++; if (bus_q[base+k] !== exp_q[k]) begin failures++; $display("FAIL tone_byte%0d got=%h exp=%h", k, bus_q[base+k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_vol_noise;
    logic [NREQ-1:0] g;
    bit ok;
    int base;
    base = bus_q.size();
    exp_q.delete();
    c_chan[1] = 2'd0; c_vol[1] = 1'b1; c_val[1] = 10'h001; c_req[1] = 1'b1;
    wait_gnt(g, ok);
    c_req[1] = 1'b0;
    checks++; if (!ok || g !== 4'b0010) begin failures++; $display("FAIL vol_gnt got=%b exp=0010", g); end
    m_ptr = 2;
    wait_idle(ok);
    c_chan[2] = 2'd3; c_vol[2] = 1'b0; c_val[2] = 10'h005; c_req[2] = 1'b1;
    wait_gnt(g, ok);
    c_req[2] = 1'b0;
    checks++; if (!ok || g !== 4'b0100) begin failures++; $display("FAIL noise_gnt got=%b exp=0100", g); end
    m_ptr = 3;
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL noise_idle busy stuck got=%b exp=0", busy); end
    exp_q.push_back(8'h91); exp_q.push_back(8'hE5);
    checks++;
    if (bus_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL volnoise_nbytes got=%0d exp=%0d", bus_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++; if (bus_q[base+k] !== exp_q[k]) begin failures++; $display("FAIL volnoise_byte%0d got=%h exp=%h", k, bus_q[base+k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] g, mask, eg;
    bit ok;
    int base, p0, e;
    base = bus_q.size();
    p0 = gnt_pulses;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) begin rand_cmd(i); c_req[i] = 1'b1; end
    for (int n = 0; n < 3 * NREQ; n++) begin
      wait_gnt(g, ok);
      for (int i = 0; i < NREQ; i++) mask[i] = c_req[i];
      e = model_pick(mask);
      eg = NREQ'(1) << e;
      checks++; if (!ok || g !== eg) begin failures++; $display("FAIL rr_order n=%0d got=%b exp=%b", n, g, eg); end
      push_exp(e);
      m_ptr = (e + 1) % NREQ;
      c_req[e] = 1'b0;
      if (n == 3 * NREQ - 1) begin
        for (int i = 0; i < NREQ; i++) c_req[i] = 1'b0;
      end else begin
        @(negedge CLK100MHZ);
        rand_cmd(e);
        c_req[e] = 1'b1;
      end
    end
    wait_idle(ok);
    repeat (5) @(negedge CLK100MHZ);
    checks++; if (gnt_pulses - p0 != 3 * NREQ) begin failures++; $display("FAIL rr_npulses got=%0d exp=%0d", gnt_pulses - p0, 3 * NREQ); end
    checks++; if (gnt_multi != 0) begin failures++; $display("FAIL rr_onehot multi-hot cycles got=%0d exp=0", gnt_multi); end
    checks++;
    if (bus_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL rr_nbytes got=%0d exp=%0d", bus_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++; if (bus_q[base+k] !== exp_q[k]) begin failures++; $display("FAIL rr_byte%0d got=%h exp=%h", k, bus_q[base+k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_withdraw;
    logic [NREQ-1:0] g, eg;
    bit ok;
    int base, p0, e;
    base = bus_q.size();
    p0 = gnt_pulses;
    exp_q.delete();
    rand_cmd(2); c_req[2] = 1'b1;
    wait_gnt(g, ok);
    e = model_pick(4'b0100);
    eg = NREQ'(1) << e;
    checks++; if (!ok || g !== eg) begin failures++; $display("FAIL wd_first_gnt got=%b exp=%b", g, eg); end
    push_exp(e);
    m_ptr = (e + 1) % NREQ;
    c_req[2] = 1'b0;
    rand_cmd(3); rand_cmd(1);
    c_req[3] = 1'b1; c_req[1] = 1'b1;
    repeat (2) @(negedge CLK100MHZ);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wd_busy got=%b exp=1", busy); end
    c_req[3] = 1'b0;
    wait_gnt(g, ok);
    e = model_pick(4'b0010);
    eg = NREQ'(1) << e;
    checks++; if (!ok || g !== eg) begin failures++; $display("FAIL wd_next_gnt got=%b exp=%b", g, eg); end
    push_exp(e);
    m_ptr = (e + 1) % NREQ;
    c_req[1] = 1'b0;
    wait_idle(ok);
    repeat (5) @(negedge CLK100MHZ);
    checks++; if (gnt_pulses - p0 != 2) begin failures++; $display("FAIL wd_npulses got=%0d exp=2", gnt_pulses - p0); end
    checks++;
    if (bus_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL wd_nbytes got=%0d exp=%0d", bus_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++; if (bus_q[base+k] !== exp_q[k]) begin failures++; $display("FAIL wd_byte%0d got=%h exp=%h", k, bus_q[base+k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_random;
    logic [NREQ-1:0] g, pend, eg, sh;
    bit ok;
    int base, e;
    base = bus_q.size();
    exp_q.delete();
    for (int r = 0; r < 8; r++) begin
      pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        sh = pend >> i;
        if (sh[0]) begin rand_cmd(i); c_req[i] = 1'b1; end
      end
      while (pend != '0) begin
        wait_gnt(g, ok);
        if (!ok) begin
          checks++; failures++; $display("FAIL rand_gnt_timeout round=%0d pend=%b", r, pend);
          for (int i = 0; i < NREQ; i++) c_req[i] = 1'b0;
          break;
        end
        e = model_pick(pend);
        eg = NREQ'(1) << e;
        checks++; if (g !== eg) begin failures++; $display("FAIL rand_gnt round=%0d got=%b exp=%b", r, g, eg); end
        push_exp(e);
        m_ptr = (e + 1) % NREQ;
        c_req[e] = 1'b0;
        pend = pend & ~eg;
        if (pend != '0 && $urandom_range(0, 3) == 0) begin
          e = model_pick(pend);
          c_req[e] = 1'b0;
          pend = pend & ~(NREQ'(1) << e);
        end
      end
      wait_idle(ok);
    end
    repeat (5) @(negedge CLK100MHZ);
    checks++; if (gnt_multi != 0) begin failures++; $display("FAIL rand_onehot multi-hot cycles got=%0d exp=0", gnt_multi); end
    checks++;
    if (bus_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL rand_nbytes got=%0d exp=%0d", bus_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++; if (bus_q[base+k] !== exp_q[k]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", k, bus_q[base+k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [NREQ-1:0] g;
    bit ok, seen;
    int base;
    rdy_auto = 1'b0;
    c_chan[0] = 2'd0; c_vol[0] = 1'b0; c_val[0] = 10'h3F9; c_req[0] = 1'b1;
    wait_gnt(g, ok);
    c_req[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK100MHZ);
      if (nCE === 1'b0) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rmid_strobe nCE never low got=%b exp=0", nCE); end
    repeat (3) @(negedge CLK100MHZ);
    #2 CPU_RESETN = 1'b0;
    #1;
    checks++; if (nCE !== 1'b1 || nWE !== 1'b1) begin failures++; $display("FAIL rmid_async nCE=%b nWE=%b exp 1/1", nCE, nWE); end
    checks++; if (busy !== 1'b0 || D !== 8'h00) begin failures++; $display("FAIL rmid_clear busy=%b D=%h exp 0/00", busy, D); end
    repeat (2) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    m_ptr = 0;
    rdy_auto = 1'b1;
    base = bus_q.size();
    c_chan[1] = 2'd2; c_vol[1] = 1'b1; c_val[1] = 10'h007; c_req[1] = 1'b1;
    wait_gnt(g, ok);
    c_req[1] = 1'b0;
    m_ptr = 2;
    checks++; if (!ok || g !== 4'b0010) begin failures++; $display("FAIL rmid_gnt got=%b exp=0010", g); end
    wait_idle(ok);
    repeat (10) @(negedge CLK100MHZ);
    checks++;
    if (bus_q.size() - base != 1) begin
      failures++; $display("FAIL rmid_nbytes got=%0d exp=1", bus_q.size() - base);
    end else begin
      checks++; if (bus_q[base] !== 8'hD7) begin failures++; $display("FAIL rmid_byte got=%h exp=D7", bus_q[base]); end
    end
  endtask

`ifdef TI_WR_TIMEOUT_EN
  task automatic test_timeout;
    logic [NREQ-1:0] g;
    bit ok, seen;
    int lowc, late;
    rdy_auto = 1'b0;
    c_chan[0] = 2'd0; c_vol[0] = 1'b0; c_val[0] = 10'h3F9; c_req[0] = 1'b1;
    wait_gnt(g, ok);
    c_req[0] = 1'b0;
    checks++; if (!ok || g !== 4'b0001) begin failures++; $display("FAIL tmo_gnt got=%b exp=0001", g); end
    m_ptr = 1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK100MHZ);
      if (nCE === 1'b0) seen = 1'b1;
    end
    lowc = 0;
    for (int n = 0; n < 100; n++) begin
      if (nCE === 1'b0) lowc++;
      else break;
      @(negedge CLK100MHZ);
    end
    checks++; if (lowc != TMO) begin failures++; $display("FAIL tmo_low_cycles got=%0d exp=%0d", lowc, TMO); end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", err_timeout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%b exp=0", busy); end
    late = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK100MHZ);
      if (nCE === 1'b0 || D !== 8'h89) late++;
    end
    checks++; if (late != 0) begin failures++; $display("FAIL tmo_no_byte1 cycles with strobe/new D got=%0d exp=0", late); end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", err_timeout); end
    rdy_auto = 1'b1;
  endtask
`else
  task automatic test_timeout;
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_tied got=%b exp=0", err_timeout); end
  endtask
`endif

  initial begin
    CPU_RESETN = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      c_req[i] = 1'b0; c_chan[i] = '0; c_vol[i] = 1'b0; c_val[i] = '0;
    end
    repeat (3) @(negedge CLK100MHZ);
    test_reset();
    test_tone();
    test_vol_noise();
    test_round_robin();
    test_withdraw();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
